// File: rtl/matmul_pkg.sv
// ============================================================================
// Module : matmul_pkg
// Brief  : Shared types and width helpers for the matmul datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WB   = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_t;

  // Product of two elements plus headroom for K accumulations.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  function automatic int addr_width_c(input int m, input int n);
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c_bram_rd_valid_pipe.sv
// ============================================================================
// Module : c_bram_rd_valid_pipe
// Brief  : RD_LATENCY-deep valid shift register aligning read grants to data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module c_bram_rd_valid_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);

  logic [RD_LATENCY-1:0] r_pipe;

  generate
    if (RD_LATENCY == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= i_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[RD_LATENCY-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = r_pipe[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/c_bram_port_arbiter.sv
// ============================================================================
// Module : c_bram_port_arbiter
// Brief  : Burst-aware arbiter sharing the C BRAM port between writeback and
//          host readout. Optional stall counters under C_BRAM_ARB_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module c_bram_port_arbiter
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int K            = 4,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, K),
  parameter int ADDR_WIDTH_C = addr_width_c(M, N),
  parameter int MAX_BURST    = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_req,
  input  logic [ADDR_WIDTH_C-1:0] wb_addr,
  input  logic [ACC_WIDTH-1:0]    wb_data,
  input  logic                    wb_last,
  output logic                    wb_gnt,
  input  logic                    host_req,
  input  logic [ADDR_WIDTH_C-1:0] host_addr,
  output logic                    host_gnt,
  output logic [ACC_WIDTH-1:0]    host_rdata,
  output logic                    host_rvalid,
  output logic                    en_c_bram,
  output logic                    we_c_bram,
  output logic [ADDR_WIDTH_C-1:0] addr_c_bram,
  output logic [ACC_WIDTH-1:0]    din_c_bram,
  input  logic [ACC_WIDTH-1:0]    dout_c_bram,
`ifdef C_BRAM_ARB_PERF_EN
  input  logic                    perf_clr,
  output logic [15:0]             wb_stall_cnt,
  output logic [15:0]             host_stall_cnt,
`endif
  output logic                    wb_active
);

  localparam int                C_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [C_CNT_W-1:0] C_MAX  = C_CNT_W'(MAX_BURST);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [C_CNT_W-1:0] r_burst_cnt;
  logic [C_CNT_W-1:0] w_cnt_next;
  logic               w_wb_gnt;
  logic               w_host_gnt;
  logic               w_beat;
  logic               w_at_max;
  logic               w_rvalid;
  logic               r_wb_active;

  always_comb begin
    w_wb_gnt   = (r_state == ARB_WB) && wb_req;
    w_host_gnt = (r_state == ARB_HOST) && host_req;
    w_beat     = w_wb_gnt || w_host_gnt;
    w_cnt_next = (w_beat && (r_burst_cnt != C_MAX)) ? r_burst_cnt + 1'b1 : r_burst_cnt;
    w_at_max   = (w_cnt_next == C_MAX);
  end

  // A saturated count only hands over once the other side is actually waiting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (wb_req)        w_state_next = ARB_WB;
        else if (host_req) w_state_next = ARB_HOST;
      end
      ARB_WB: begin
        if (!wb_req || wb_last)    w_state_next = host_req ? ARB_HOST : ARB_IDLE;
        else if (w_at_max && host_req) w_state_next = ARB_HOST;
      end
      ARB_HOST: begin
        if (!host_req)             w_state_next = wb_req ? ARB_WB : ARB_IDLE;
        else if (w_at_max && wb_req) w_state_next = ARB_WB;
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_burst_cnt <= '0;
      r_wb_active <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= (w_state_next != r_state) ? '0 : w_cnt_next;
      r_wb_active <= (w_state_next == ARB_WB);
    end
  end

  c_bram_rd_valid_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_host_gnt),
    .o_valid (w_rvalid)
  );

  always_comb begin
    wb_gnt      = w_wb_gnt;
    host_gnt    = w_host_gnt;
    en_c_bram   = w_beat;
    we_c_bram   = w_wb_gnt;
    addr_c_bram = w_wb_gnt ? wb_addr : (w_host_gnt ? host_addr : '0);
    din_c_bram  = w_wb_gnt ? wb_data : '0;
    host_rvalid = w_rvalid;
    host_rdata  = w_rvalid ? dout_c_bram : '0;
    wb_active   = r_wb_active;
  end

`ifdef C_BRAM_ARB_PERF_EN
  logic [15:0] r_wb_stall_cnt;
  logic [15:0] r_host_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_stall_cnt   <= '0;
      r_host_stall_cnt <= '0;
    end else if (perf_clr) begin
      r_wb_stall_cnt   <= '0;
      r_host_stall_cnt <= '0;
    end else begin
      if (wb_req && !w_wb_gnt && (r_wb_stall_cnt != 16'hFFFF))
        r_wb_stall_cnt <= r_wb_stall_cnt + 16'd1;
      if (host_req && !w_host_gnt && (r_host_stall_cnt != 16'hFFFF))
        r_host_stall_cnt <= r_host_stall_cnt + 16'd1;
    end
  end

  assign wb_stall_cnt   = r_wb_stall_cnt;
  assign host_stall_cnt = r_host_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_c_bram_port_arbiter.sv
// ============================================================================
// Module : tb_c_bram_port_arbiter
// Brief  : Self-checking bench for c_bram_port_arbiter with a 1-cycle BRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_c_bram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_req, wb_last, host_req;
  logic [AW-1:0] wb_addr, host_addr;
  logic [DW-1:0] wb_data;
  logic          wb_gnt, host_gnt, host_rvalid, en_c_bram, we_c_bram, wb_active;
  logic [AW-1:0] addr_c_bram;
  logic [DW-1:0] host_rdata, din_c_bram, dout_c_bram;
`ifdef C_BRAM_ARB_PERF_EN
  logic          perf_clr;
  logic [15:0]   wb_stall_cnt, host_stall_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  c_bram_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb_req      (wb_req),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_last     (wb_last),
    .wb_gnt      (wb_gnt),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .en_c_bram   (en_c_bram),
    .we_c_bram   (we_c_bram),
    .addr_c_bram (addr_c_bram),
    .din_c_bram  (din_c_bram),
    .dout_c_bram (dout_c_bram),
`ifdef C_BRAM_ARB_PERF_EN
    .perf_clr       (perf_clr),
    .wb_stall_cnt   (wb_stall_cnt),
    .host_stall_cnt (host_stall_cnt),
`endif
    .wb_active   (wb_active)
  );

  // BRAM model, read latency 1
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (en_c_bram) begin
      if (we_c_bram) mem[addr_c_bram] <= din_c_bram;
      else           dout_c_bram      <= mem[addr_c_bram];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] d_a(input int i);
    return 34'h2_0000_0002 + DW'(i);
  endfunction
  function automatic logic [DW-1:0] d_c(input int i);
    return 34'h0_1234_0000 + DW'(i);
  endfunction
  function automatic logic [DW-1:0] d_d(input int i);
    return 34'h1_0000_0100 + DW'(i);
  endfunction

  function automatic logic [127:0] all_outs();
    return {wb_gnt, host_gnt, host_rdata, host_rvalid, en_c_bram, we_c_bram,
            addr_c_bram, din_c_bram, wb_active};
  endfunction

  typedef struct {
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_last;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic          e_wb_gnt;
    logic          e_host_gnt;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_rvalid;
    logic          e_active;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int wi, hi, cyc, gaps, first, code, expc, bad_mem;
    logic [DW-1:0] t0, t1, t2, t3, t4;
    t0 = 34'h3_0000_00A0; t1 = t0 + 1; t2 = t0 + 2; t3 = t0 + 3; t4 = t0 + 4;
    //          wr wa    wd  wl hr ha     wg hg en we addr din rv act
    tbl[0]  = '{1, 4'd0, t0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, '0, 0, 0};
    tbl[1]  = '{1, 4'd0, t0, 0, 0, 4'd0,  1, 0, 1, 1, 4'd0, t0, 0, 1};
    tbl[2]  = '{1, 4'd1, t1, 0, 0, 4'd0,  1, 0, 1, 1, 4'd1, t1, 0, 1};
    tbl[3]  = '{1, 4'd2, t2, 0, 1, 4'd5,  1, 0, 1, 1, 4'd2, t2, 0, 1};
    tbl[4]  = '{1, 4'd3, t3, 0, 1, 4'd5,  1, 0, 1, 1, 4'd3, t3, 0, 1};
    tbl[5]  = '{1, 4'd4, t4, 0, 1, 4'd5,  0, 1, 1, 0, 4'd5, '0, 0, 0};
    tbl[6]  = '{1, 4'd4, t4, 0, 1, 4'd6,  0, 1, 1, 0, 4'd6, '0, 1, 0};
    tbl[7]  = '{1, 4'd4, t4, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, '0, 1, 0};
    tbl[8]  = '{1, 4'd4, t4, 1, 0, 4'd0,  1, 0, 1, 1, 4'd4, t4, 0, 1};
    tbl[9]  = '{0, 4'd0, '0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, '0, 0, 0};
    tbl[10] = '{0, 4'd0, '0, 0, 1, 4'd7,  0, 0, 0, 0, 4'd0, '0, 0, 0};
    tbl[11] = '{0, 4'd0, '0, 0, 1, 4'd7,  0, 1, 1, 0, 4'd7, '0, 0, 0};
    tbl[12] = '{0, 4'd0, '0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, '0, 1, 0};
    tbl[13] = '{0, 4'd0, '0, 0, 0, 4'd0,  0, 0, 0, 0, 4'd0, '0, 0, 0};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    dout_c_bram = '0;
    rst = 1'b1; wb_req = 0; wb_last = 0; host_req = 0;
    wb_addr = '0; host_addr = '0; wb_data = '0;
`ifdef C_BRAM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // ---- reset state, then reset in the middle of a writeback burst
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    wi = 0;
    for (cyc = 0; cyc < 10 && wi < 2; cyc++) begin
      @(posedge clk); #1;
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_a(wi);
      @(negedge clk);
      if (wb_gnt) wi++;
    end
    check("pre_reset_writes", 128'(wi), 128'd2);
    @(posedge clk); #1;
    wb_addr = 4'd2; wb_data = d_a(2);
    #2 rst = 1'b1;
    #1 check("reset_mid_burst_async", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0; wb_addr = 4'd0; wb_data = d_a(0);
    @(posedge clk); #1;
    check("restart_first_gnt", {wb_gnt, addr_c_bram}, {1'b1, 4'd0});
    wb_req = 0;
    @(posedge clk); #1;

    // ---- table-driven vectors
    for (int v = 0; v < 14; v++) begin
      if (v != 0) begin
        @(posedge clk); #1;
      end
      wb_req = tbl[v].wb_req; wb_addr = tbl[v].wb_addr; wb_data = tbl[v].wb_data;
      wb_last = tbl[v].wb_last; host_req = tbl[v].host_req; host_addr = tbl[v].host_addr;
      @(negedge clk);
      check($sformatf("vec%0d", v),
            {wb_gnt, host_gnt, en_c_bram, we_c_bram, addr_c_bram, din_c_bram, host_rvalid, wb_active},
            {tbl[v].e_wb_gnt, tbl[v].e_host_gnt, tbl[v].e_en, tbl[v].e_we, tbl[v].e_addr,
             tbl[v].e_din, tbl[v].e_rvalid, tbl[v].e_active});
    end

    // ---- writeback only: 16 consecutive beats
    wi = 0; gaps = 0; first = -1;
    for (cyc = 0; cyc < 40 && wi < 16; cyc++) begin
      @(posedge clk); #1;
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_a(wi); wb_last = (wi == 15);
      host_req = 0;
      @(negedge clk);
      if (wb_gnt) begin
        check($sformatf("wb_only_beat%0d", wi), {we_c_bram, en_c_bram, addr_c_bram, din_c_bram},
              {1'b1, 1'b1, AW'(wi), d_a(wi)});
        if (first < 0) first = cyc;
        wi++;
      end else if (first >= 0) gaps++;
    end
    check("wb_only_done", 128'(wi), 128'd16);
    check("wb_only_no_gaps", 128'(gaps), 128'd0);
    @(posedge clk); #1;
    wb_req = 0; wb_last = 0;
    @(negedge clk);
    check("wb_only_idle_after", {wb_active, wb_gnt}, 2'b00);

    // ---- read latency: addr 3 holds 0x2_0000_0005
    @(posedge clk); #1;
    host_req = 1; host_addr = 4'd3;
    @(negedge clk);
    check("rd_idle_no_gnt", 128'(host_gnt), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_gnt", {host_gnt, host_rvalid}, 2'b10);
    @(posedge clk); #1;
    host_req = 0;
    @(negedge clk);
    check("rd_rvalid_data", {host_rvalid, host_rdata}, {1'b1, 34'h2_0000_0005});
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_rvalid_single", {host_rvalid, host_rdata}, '0);

    // ---- simultaneous request: 4 wb, 4 host, remaining 12 wb
    wi = 0; hi = 0;
    for (cyc = 0; cyc < 40 && wi < 16; cyc++) begin
      @(posedge clk); #1;
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_c(wi); wb_last = (wi == 15);
      host_req = (hi < 4); host_addr = AW'(hi);
      @(negedge clk);
      code = {30'd0, wb_gnt, host_gnt};
      expc = (cyc == 0) ? 0 : (cyc <= 4) ? 2 : (cyc <= 8) ? 1 : 2;
      check($sformatf("sim_cyc%0d", cyc), 128'(code), 128'(expc));
      if (wb_gnt) wi++;
      if (host_gnt) hi++;
    end
    check("sim_counts", {32'(cyc), 32'(wi), 32'(hi)}, {32'd21, 32'd16, 32'd4});
    @(posedge clk); #1;
    wb_req = 0; wb_last = 0; host_req = 0;

    // ---- wb_req drops after 6 beats while host waits
    wi = 0;
    for (cyc = 0; cyc < 20 && wi < 6; cyc++) begin
      @(posedge clk); #1;
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_d(wi); wb_last = 0;
      @(negedge clk);
      if (wb_gnt) wi++;
    end
    check("drop_first6", 128'(wi), 128'd6);
    @(posedge clk); #1;
    wb_req = 0; host_req = 1; host_addr = 4'd3;
    @(negedge clk);
    check("drop_cycle", {wb_gnt, host_gnt, en_c_bram}, 3'b000);
    @(posedge clk); #1;
    wb_req = 1; wb_addr = AW'(wi); wb_data = d_d(wi);
    @(negedge clk);
    check("drop_host_gnt", {wb_gnt, host_gnt}, 2'b01);
    @(posedge clk); #1;
    host_req = 0;
    @(negedge clk);
    check("drop_handback", {wb_gnt, host_gnt}, 2'b00);
    for (cyc = 0; cyc < 30 && wi < 16; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_d(wi); wb_last = (wi == 15);
      @(negedge clk);
      if (wb_gnt) wi++;
    end
    check("drop_resume_done", 128'(wi), 128'd16);
    @(posedge clk); #1;
    wb_req = 0; wb_last = 0;
    @(negedge clk);
    bad_mem = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== d_d(i)) bad_mem++;
    check("drop_mem_contents", 128'(bad_mem), 128'd0);

`ifdef C_BRAM_ARB_PERF_EN
    // ---- stall counter: host waits 5 cycles behind a writeback burst
    @(posedge clk); #1;
    perf_clr = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    wi = 0; hi = 0;
    for (cyc = 0; cyc < 20 && hi == 0; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      wb_req = 1; wb_addr = AW'(wi); wb_data = d_c(wi); wb_last = 0;
      host_req = 1; host_addr = 4'd0;
      @(negedge clk);
      if (wb_gnt) wi++;
      if (host_gnt) begin
        hi++;
        check("perf_host_stall", 128'(host_stall_cnt), 128'd5);
      end
    end
    check("perf_host_granted", 128'(hi), 128'd1);
    @(posedge clk); #1;
    wb_req = 0; host_req = 0; perf_clr = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    @(negedge clk);
    check("perf_clr", {host_stall_cnt, wb_stall_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
